// File: rtl/dec_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : dec_scan_if
// Brief    : Control and decoded-line bundle for dec_scan_driver.
// Revision : 1.0 - initial release
// ============================================================================
interface dec_scan_if #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
);
    logic                 en;
    logic                 mode;
    logic [N-1:0]         w;
    logic                 w_valid;
    logic [DWELL_W-1:0]   dwell;
    logic [(1<<N)-1:0]    out;
    logic [N-1:0]         idx;
    logic                 wrap;

    modport master (
        output en, mode, w, w_valid, dwell,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, w, w_valid, dwell,
        output out, idx, wrap
    );
endinterface
`default_nettype wire

// File: rtl/dec_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : dec_scan_driver
// Brief    : Registered N-to-2^N one-hot decoder with direct and scan modes.
//            Optional anti-ghosting blanking: define DEC_SCAN_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dec_scan_driver #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    dec_scan_if.slave bus
);
    localparam int W = 1 << N;

`ifdef DEC_SCAN_BLANK_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIRECT = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;

    localparam logic [N-1:0]       IDX_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]       OUT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [N-1:0]       r_idx;
    logic [W-1:0]       r_out;
    logic               r_wrap;
    logic               r_blank;

    logic [N-1:0]       w_idx_inc;
    logic               w_adv;
    logic [W-1:0]       w_line_inc;
    logic [W-1:0]       w_line_sel;
    logic [W-1:0]       w_line_cur;

    assign w_idx_inc  = r_idx + IDX_ONE;
    assign w_adv      = (r_cnt >= bus.dwell);
    assign w_line_inc = OUT_ONE << w_idx_inc;
    assign w_line_sel = OUT_ONE << bus.w;
    assign w_line_cur = OUT_ONE << r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_out   <= '0;
            r_wrap  <= 1'b0;
            r_blank <= 1'b0;
        end else if (!bus.en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_out   <= '0;
            r_wrap  <= 1'b0;
            r_blank <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_wrap  <= 1'b0;
                    r_blank <= 1'b0;
                    if (bus.mode) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        r_out   <= OUT_ONE;
                    end else begin
                        r_state <= S_DIRECT;
                    end
                end
                S_DIRECT: begin
                    r_cnt  <= '0;
                    r_wrap <= 1'b0;
                    if (bus.mode) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        r_out   <= OUT_ONE;
                        r_blank <= 1'b0;
                    end else if (r_blank) begin
                        // Blank slot ends: show the pending line, or a newer one.
                        r_blank <= 1'b0;
                        if (bus.w_valid) begin
                            r_idx <= bus.w;
                            r_out <= w_line_sel;
                        end else begin
                            r_out <= w_line_cur;
                        end
                    end else if (bus.w_valid) begin
                        r_idx <= bus.w;
                        if (BLANK_EN && (r_out != '0) && (bus.w != r_idx)) begin
                            r_out   <= '0;
                            r_blank <= 1'b1;
                        end else begin
                            r_out <= w_line_sel;
                        end
                    end
                end
                S_SCAN: begin
                    if (!bus.mode) begin
                        r_state <= S_DIRECT;
                        r_out   <= '0;
                        r_cnt   <= '0;
                        r_wrap  <= 1'b0;
                        r_blank <= 1'b0;
                    end else if (r_blank) begin
                        r_out   <= w_line_cur;
                        r_blank <= 1'b0;
                        r_cnt   <= '0;
                        r_wrap  <= 1'b0;
                    end else if (w_adv) begin
                        // >= lets a lowered dwell cut the current hold short.
                        r_cnt  <= '0;
                        r_idx  <= w_idx_inc;
                        r_wrap <= (w_idx_inc == '0);
                        if (BLANK_EN) begin
                            r_out   <= '0;
                            r_blank <= 1'b1;
                        end else begin
                            r_out <= w_line_inc;
                        end
                    end else begin
                        r_cnt  <= r_cnt + CNT_ONE;
                        r_wrap <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_out   <= '0;
                    r_wrap  <= 1'b0;
                    r_blank <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = r_out;
    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: doc/dec_scan_driver.md
Name: dec_scan_driver

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable; the sequential successor of the team's 2-to-4 and 4-to-16 combinational decoders.
- Two modes:
  - Direct: latches a select code on a valid strobe and drives the decoded line.
  - Scan: auto-steps a one-hot line through all 2^N outputs, holding each for a programmable dwell.
- Drives display digit/row strobes and keypad column scanning.

Parameters:
N, 4, select width; output width is 2^N.
DWELL_W, 8, width of dwell count input and internal dwell counter.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
en  in  1  global enable; 0 forces outputs low (synchronous).
mode  in  1  0 = direct, 1 = scan.
w  in  N  select code, direct mode.
w_valid  in  1  strobe qualifying w, direct mode.
dwell  in  DWELL_W  scan hold count; each position is active dwell+1 cycles.
out  out  2^N  one-hot decoded lines, registered.
idx  out  N  index of the current/last asserted line, registered.
wrap  out  1  one-cycle pulse when scan wraps from 2^N-1 to 0.

Behaviour:
- Reset (rst_n=0, async): out=0, idx=0, wrap=0, dwell counter cnt=0, state=IDLE. On release, first update is on the next rising edge.
- All outputs registered. out is always zero or exactly one-hot, with out = 1<<idx whenever nonzero.
- States: IDLE, DIRECT, SCAN.
- Transitions, evaluated each clock:
  - en=0 from any state: IDLE next cycle; out=0, idx=0, cnt=0, wrap=0.
  - IDLE, en=1, mode=0: DIRECT. out stays 0 until first w_valid.
  - IDLE, en=1, mode=1: SCAN. Next cycle idx=0, out=1, cnt=0.
  - DIRECT, mode becomes 1: SCAN, entry as above (restart at idx 0).
  - SCAN, mode becomes 0: DIRECT. out=0 next cycle; idx holds; cnt=0.
- DIRECT mode:
  - w_valid=1: idx<=w, out<=1<<w. Latency 1 clock.
  - w_valid=0: out/idx hold.
  - Repeated w_valid with the same w: no visible change.
- SCAN mode:
  - Each cycle: if cnt>=dwell, then cnt<=0, idx<=idx+1 (mod 2^N), out<=1<<(idx+1); else cnt<=cnt+1.
  - dwell=0: advance every cycle.
  - Comparison is >=, so lowering dwell mid-hold below cnt advances on the next clock. Raising dwell extends the current hold.
  - wrap=1 for exactly the cycle in which idx becomes 0 through wrap-around; not on scan entry.
  - w and w_valid are ignored.
- Simultaneous en=0 and any other input: en=0 wins.
- Simultaneous mode change and w_valid: mode transition rule wins; w_valid is ignored that cycle.

Optional Feature:
- Macro: DEC_SCAN_BLANK_EN (anti-ghosting blanking).
- Defined, scan:
  - After the dwell+1 active cycles of a position, one blank cycle with out=0. idx updates at the start of the blank cycle; wrap pulses in the blank cycle.
  - The next line asserts the cycle after the blank; period per position is dwell+2.
- Defined, direct: w_valid with w != idx while out != 0 gives out=0 for one cycle, then 1<<w (latency 2). Otherwise latency 1.
- Not defined: no blank cycles; timing as in Behaviour.

Test Plan (N=4, DWELL_W=8):
1. Reset and idle: rst_n low mid-scan with out=16'h0100 -> out=0, idx=0, wrap=0 immediately, without a clock edge. Release with en=0 -> out remains 0.
2. Direct decode: en=1, mode=0; w=4'hA with w_valid for 1 cycle -> out=16'h0400, idx=10 one clock later. Then w=4'h3 with w_valid=0 -> out holds 16'h0400.
3. Scan timing: mode=1, dwell=2 -> out=0x0001 for 3 cycles, then 0x0002 for 3 cycles, through 0x8000. The return to 0x0001 has wrap=1 for that single cycle; full period 48 cycles.
4. dwell=0 scan -> out shifts each cycle, wrap every 16 cycles. Drop dwell from 200 to 5 at cnt=50 -> advance on the next clock.
5. Mode/enable interplay: mode 1->0 at idx=7 -> out=0, idx=7; then w_valid with w=2 -> out=0x0004. en=0 pulse during scan -> out=0, then restart at 0x0001.
6. With DEC_SCAN_BLANK_EN, dwell=1 -> pattern per position is 2 active cycles then 1 zero cycle. Direct change from w=1 to w=5 -> one cycle out=0, then 0x0020.
